// File: rtl/bcd_digit_converter_pkg.sv
// Shared types and constants for the binary-to-BCD display converter.
package bcd_digit_converter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         BCD_MAX     = 9999;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam int         BCD_DIGITS  = 4;

endpackage

// File: rtl/bcd_digit_converter_if.sv
// Handshake bus between the correlator datapath, the converter and the display driver.
interface bcd_digit_converter_if #(
  parameter int IN_W = 14
) ();

  logic            in_valid;
  logic [IN_W-1:0] in_data;
  logic            in_ready;
  logic [15:0]     bcd_out;
  logic            out_valid;
  logic            ovf;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  bcd_out,
    input  out_valid,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output bcd_out,
    output out_valid,
    output ovf
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] corr
);

  assign corr = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bcd_digit_converter.sv
// Iterative binary-to-BCD converter with saturation at 9999 and a stable registered result.
// Optional build macro BCD_DIGIT_CONVERTER_BLANK_EN enables leading-zero blanking of bcd_out.
module bcd_digit_converter
  import bcd_digit_converter_pkg::*;
#(
  parameter int IN_W = 14
) (
  input  logic                  clk0,
  input  logic                  rst,
  bcd_digit_converter_if.slave  bus
);

  localparam logic [16:0] SAT_VAL_W = 17'(BCD_MAX);

  state_t          state_r;
  logic [IN_W-1:0] bin_r;
  logic [15:0]     bcd_r;
  logic [4:0]      cnt_r;
  logic            ovf_flag_r;
  logic [15:0]     bcd_out_r;
  logic            ovf_r;
  logic            out_valid_r;

  logic [16:0]     in_wide_s;
  logic            sat_s;
  logic [IN_W-1:0] load_val_s;
  logic [15:0]     corr_s;
  logic [15:0]     result_s;

  // Narrow inputs can never exceed 9999, so the compare folds to false there.
  assign in_wide_s  = 17'(bus.in_data);
  assign sat_s      = (in_wide_s > SAT_VAL_W);
  assign load_val_s = sat_s ? SAT_VAL_W[IN_W-1:0] : bus.in_data;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .digit (bcd_r[4*g +: 4]),
      .corr  (corr_s[4*g +: 4])
    );
  end

`ifdef BCD_DIGIT_CONVERTER_BLANK_EN
  function automatic logic [15:0] blank_lead(input logic [15:0] raw);
    logic [15:0] res;
    logic        lead;
    res  = raw;
    lead = 1'b1;
    for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
      if (lead && (raw[4*i +: 4] == 4'd0)) begin
        res[4*i +: 4] = DIGIT_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

  assign result_s = blank_lead(bcd_r);
`else
  assign result_s = bcd_r;
`endif

  // Conversion state machine, working registers and the held result.
  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      bin_r       <= '0;
      bcd_r       <= 16'h0000;
      cnt_r       <= 5'd0;
      ovf_flag_r  <= 1'b0;
      bcd_out_r   <= 16'h0000;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            bin_r      <= load_val_s;
            bcd_r      <= 16'h0000;
            cnt_r      <= 5'(IN_W);
            ovf_flag_r <= sat_s;
            state_r    <= SHIFT;
          end
        end
        SHIFT: begin
          // The top corrected bit falls off; values up to 9999 never use it.
          bcd_r <= 16'({corr_s, bin_r[IN_W-1]});
          bin_r <= bin_r << 1;
          cnt_r <= cnt_r - 5'd1;
          if (cnt_r == 5'd1) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          bcd_out_r   <= result_s;
          ovf_r       <= ovf_flag_r;
          out_valid_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.bcd_out   = bcd_out_r;
  assign bus.ovf       = ovf_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_bcd_digit_converter.sv
// Randomised self-checking bench for bcd_digit_converter against an arithmetic BCD model.
module tb_bcd_digit_converter;

  localparam int IN_W = 14;

  logic clk0 = 1'b0;
  logic rst  = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  bcd_digit_converter_if #(.IN_W(IN_W)) bus ();

  bcd_digit_converter #(.IN_W(IN_W)) dut (
    .clk0 (clk0),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk0 = ~clk0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: saturate, split into decimal digits, optionally blank leading zeros.
  function automatic logic [15:0] ref_bcd(input int v);
    int          s;
    int          d [4];
    logic [15:0] r;
    bit          lead;
    s = (v > 9999) ? 9999 : v;
    d[0] = s % 10;
    d[1] = (s / 10) % 10;
    d[2] = (s / 100) % 10;
    d[3] = (s / 1000) % 10;
`ifdef BCD_DIGIT_CONVERTER_BLANK_EN
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && d[i] == 0) d[i] = 15;
      else lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    r = {d[3][3:0], d[2][3:0], d[1][3:0], d[0][3:0]};
    return r;
  endfunction

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    @(negedge clk0);
    while (!bus.in_ready && k < 40) begin
      @(negedge clk0);
      k++;
    end
    check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_conv(input int v, input string tag);
    logic [15:0] prev;
    int          j;
    bit          found;
    bit          hold_bad;
    wait_ready(tag);
    prev = bus.bcd_out;
    bus.in_valid = 1'b1;
    bus.in_data  = 14'(v);
    @(posedge clk0);
    #1;
    bus.in_valid = 1'b0;
    j = 0;
    found = 1'b0;
    hold_bad = 1'b0;
    while (!found && j < 40) begin
      @(negedge clk0);
      if (j == 0) check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
      if (bus.out_valid) found = 1'b1;
      else begin
        if (bus.bcd_out !== prev) hold_bad = 1'b1;
        j++;
      end
    end
    check({tag, "_lat"}, 32'(j), 32'(IN_W + 1));
    check({tag, "_hold"}, 32'(hold_bad), 32'd0);
    check({tag, "_bcd"}, 32'(bus.bcd_out), 32'(ref_bcd(v)));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(v > 9999));
    @(negedge clk0);
    check({tag, "_pulse"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    int  v;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    repeat (2) @(negedge clk0);
    check("rst_rdy", 32'(bus.in_ready), 32'd1);
    check("rst_bcd", 32'(bus.bcd_out), 32'h0000);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_ov", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;

    run_conv(1234, "d1234");
    run_conv(0, "d0");
    run_conv(9999, "d9999");
    run_conv(12000, "sat");
    run_conv(5, "d5");
    run_conv(42, "d42");
    run_conv(1002, "d1002");
    run_conv(16383, "dmax");
    run_conv(10000, "d10000");

    // Source holds in_valid: 77 first, then 88 until it is taken.
    wait_ready("h77");
    bus.in_valid = 1'b1;
    bus.in_data  = 14'd77;
    @(posedge clk0);
    #1;
    bus.in_data = 14'd88;
    cyc = 0;
    seen = 1'b0;
    while (cyc < 40) begin
      @(negedge clk0);
      cyc++;
      if (bus.out_valid) begin
        check("h77_bcd", 32'(bus.bcd_out), 32'(ref_bcd(77)));
        seen = 1'b1;
      end
      if (bus.in_ready) break;
    end
    check("h77_seen", 32'(seen), 32'd1);
    check("h88_gap", 32'(cyc), 32'(IN_W + 2));
    @(posedge clk0);
    #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(negedge clk0);
      cyc++;
    end
    check("h88_bcd", 32'(bus.bcd_out), 32'(ref_bcd(88)));

    // Abort mid-conversion with reset.
    run_conv(1234, "pre");
    wait_ready("ab");
    bus.in_valid = 1'b1;
    bus.in_data  = 14'd5555;
    @(posedge clk0);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk0);
    #1;
    rst = 1'b1;
    #1;
    check("ab_rdy", 32'(bus.in_ready), 32'd1);
    check("ab_bcd", 32'(bus.bcd_out), 32'h0000);
    @(negedge clk0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk0);
      if (bus.out_valid) seen = 1'b1;
    end
    check("ab_noval", 32'(seen), 32'd0);
    check("ab_bcd2", 32'(bus.bcd_out), 32'h0000);
    run_conv(5555, "d5555");

    for (int i = 0; i < 30; i++) begin
      v = (i % 3 == 0) ? int'($urandom_range(16383, 10000)) : int'($urandom_range(9999, 0));
      repeat ($urandom_range(3, 0)) @(negedge clk0);
      run_conv(v, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
